// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types, constants and hex-to-segment decode for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    localparam logic [3:0] ANODE_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode scan controller with dead-time blanking and frame-aligned value update.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    scan_state_t      state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             boundary;

    // {value, dp} pairs: bits [19:4] are the hex nibbles, [3:0] the decimal points
    logic [19:0]      shadow;
    logic [19:0]      active;
    logic             pending;

    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic             lead_blank;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_W'(1);
        boundary  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                    boundary  = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + 2'd1;
                        cnt_nxt   = '0;
                        boundary  = (idx == 2'd3);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A load coinciding with a boundary bypasses the shadow so the newest value wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                shadow <= {value, dp_in};
            end
            if (boundary) begin
                if (load) begin
                    active <= {value, dp_in};
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign cur_nibble = active[4 + 4*idx +: 4];

    seg_decoder u_seg_decoder (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_blank = 1'b0;
        case (idx)
            2'd1:    lead_blank = (active[19:8]  == 12'h000);
            2'd2:    lead_blank = (active[19:12] == 8'h00);
            2'd3:    lead_blank = (active[19:16] == 4'h0);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Gating on enable darkens the pins on the edge that samples enable low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode       <= ANODE_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (enable && (state == DRIVE)) begin
                anode <= ANODE_SEL[idx];
                seg   <= lead_blank ? SEG_OFF : cur_seg;
                dp    <= ~active[idx];
            end else begin
                anode <= ANODE_OFF;
                seg   <= SEG_OFF;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .anode       (anode),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_dark(input string name);
        checks++;
        if ({anode, seg, dp, frame_start} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s: anode=%b seg=%h dp=%b fs=%b, required anode=1111 seg=7f dp=1 fs=0",
                     name, anode, seg, dp, frame_start);
        end
    endtask

    // Runs one 32-cycle frame starting just after a boundary edge; optional loads at cycles la/lb
    task automatic check_frame(input string name,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] lit,
                               input int la, input logic [15:0] lva, input logic [3:0] lda,
                               input int lb, input logic [15:0] lvb, input logic [3:0] ldb);
        logic [3:0] sel [4];
        logic [6:0] exp_s [4];
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        int         slot;
        int         pos;
        sel   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_s = '{s0, s1, s2, s3};
        for (int c = 1; c <= 32; c++) begin
            if (c == la) begin
                load = 1'b1; value = lva; dp_in = lda;
            end else if (c == lb) begin
                load = 1'b1; value = lvb; dp_in = ldb;
            end else begin
                load = 1'b0;
            end
            step();
            load = 1'b0;
            slot = (c - 1) / 8;
            pos  = (c - 1) % 8;
            if (pos < 2) begin
                e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = sel[slot]; e_seg = exp_s[slot]; e_dp = ~lit[slot];
            end
            e_fs = (c == 32);
            checks++;
            if ({anode, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                errors++;
                $display("FAIL %s cycle %0d: anode=%b seg=%h dp=%b fs=%b, required anode=%b seg=%h dp=%b fs=%b",
                         name, c, anode, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        repeat (3) @(negedge clk);
        check_dark("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_dark("idle_disabled");
        end
    endtask

    task automatic test_start();
        load = 1'b1; value = 16'h1234; dp_in = 4'b0001;
        step();
        load = 1'b0;
        check_dark("load_while_disabled");
        enable = 1'b1;
        step();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL start_frame_pulse: frame_start=%b, required 1", frame_start);
        end
        check_frame("frame_1234_a", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0001, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    endtask

    task automatic test_double_buffer();
        check_frame("frame_1234_midload", 7'h19, 7'h30, 7'h24, 7'h79, 4'b0001,
                    12, 16'hABCD, 4'b0000, 0, 16'h0, 4'h0);
        check_frame("frame_abcd", 7'h21, 7'h46, 7'h03, 7'h08, 4'b0000,
                    5, 16'h5555, 4'b0000, 20, 16'h6666, 4'b1111);
        check_frame("frame_6666_last_wins", 7'h02, 7'h02, 7'h02, 7'h02, 4'b1111,
                    32, 16'h9870, 4'b0010, 0, 16'h0, 4'h0);
    endtask

    task automatic test_boundary_load();
        check_frame("frame_9870_boundary", 7'h40, 7'h78, 7'h00, 7'h10, 4'b0010,
                    10, 16'h1111, 4'b0000, 32, 16'hFE3C, 4'b1000);
        check_frame("frame_fe3c_port_priority", 7'h46, 7'h30, 7'h06, 7'h0E, 4'b1000,
                    0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    endtask

    task automatic test_enable_drop();
        for (int c = 1; c <= 20; c++) step();
        checks++;
        if ({anode, seg, dp} !== {4'b1011, 7'h06, 1'b1}) begin
            errors++;
            $display("FAIL drop_pre_digit2: anode=%b seg=%h dp=%b, required anode=1011 seg=06 dp=1",
                     anode, seg, dp);
        end
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_dark("enable_dropped");
        end
        enable = 1'b1;
        step();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reenable_frame_pulse: frame_start=%b, required 1", frame_start);
        end
        check_frame("frame_reenable_fe3c", 7'h46, 7'h30, 7'h06, 7'h0E, 4'b1000,
                    32, 16'h0042, 4'b0000, 0, 16'h0, 4'h0);
    endtask

    task automatic test_leading_zero();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check_frame("frame_0042", 7'h24, 7'h19, 7'h7F, 7'h7F, 4'b0000,
                    32, 16'h0000, 4'b0100, 0, 16'h0, 4'h0);
        check_frame("frame_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0100,
                    0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
`else
        check_frame("frame_0042", 7'h24, 7'h19, 7'h40, 7'h40, 4'b0000,
                    32, 16'h0000, 4'b0100, 0, 16'h0, 4'h0);
        check_frame("frame_0000", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0100,
                    0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_start();
        test_double_buffer();
        test_boundary_load();
        test_enable_drop();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Cycles an active-low one-hot anode select across digits 0..3 and drives the matching segment pattern for each digit.
- Inserts a dead-time blank between digits to suppress ghosting.
- Display value is double-buffered: a new value takes effect only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 100000, total clk cycles per digit slot (1 ms at 100 MHz). Constraint: > BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off. Constraint: >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scan runs; 0 = display dark
- load  in  1  single-cycle strobe; captures value/dp_in
- value  in  16  four hex nibbles; nibble i drives digit i
- dp_in  in  4  decimal point per digit, 1 = lit
- anode  out  4  active-low digit select
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- frame_start  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: anode=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - Internal: state=IDLE, digit idx=0, slot counter=0, shadow=0, active=0, pending=0.
- All outputs are registered: pins reflect the state/idx of the previous cycle.
- Anode map: idx0=4'b1110, idx1=4'b1101, idx2=4'b1011, idx3=4'b0111.
- Hex decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- FSM states: IDLE, BLANK, DRIVE.
- IDLE:
  - anode=1111, seg=7F, dp=1.
  - enable=1 -> BLANK with idx=0; this entry is a frame boundary.
- BLANK:
  - anode=1111, seg=7F, dp=1.
  - Lasts exactly BLANK_CYCLES cycles, then -> DRIVE.
- DRIVE:
  - anode=map(idx), seg=decode(active[4*idx+:4]), dp=~active_dp[idx].
  - Lasts exactly REFRESH_DIV-BLANK_CYCLES cycles, then -> BLANK with idx=idx+1 mod 4.
  - The wrap 3->0 is a frame boundary.
- enable=0 in any state: -> IDLE on the next edge, idx=0, counter=0. Shadow, active and pending are retained.
- load=1:
  - shadow <= {value, dp_in}; pending <= 1.
  - Repeated loads before a boundary overwrite shadow; last one wins.
- Frame boundary:
  - If pending=1: active <= shadow, pending <= 0.
  - If load=1 in the same cycle: active <= port value directly and pending stays 0. The port value takes priority over shadow.
  - frame_start=1 for one cycle (registered), whether or not an update occurred.
- Loads outside a boundary never change active; digits shown mid-frame are unaffected.
- Timing: full frame = 4*REFRESH_DIV cycles. Counter width = $clog2(REFRESH_DIV); the counter clears on every state change.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i = 1..3) shows seg=7F when active nibbles i..3 are all zero.
  - Digit 0 is always shown.
  - dp is unaffected by blanking.
  - The anode still strobes normally.
- Undefined: all four digits are always decoded, so 16'h0042 displays "0042".

Decomposition:
- Package seven_seg_pkg:
  - scan_state_t enum {IDLE, BLANK, DRIVE}.
  - Constants ANODE_OFF=4'b1111 and SEG_OFF=7'h7F.
  - ANODE_SEL[4] table.
  - Function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module seg_decoder: purely combinational, wraps hex_to_seg, one instance.
- Top holds the FSM, counter, shadow/active registers and output registers.

Test Plan (all scenarios use REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset held, then released with enable=0 -> anode=1111, seg=7F, dp=1, frame_start=0 indefinitely.
- load value=16'h1234, dp_in=4'b0001, then enable=1:
  - frame_start pulses.
  - Per slot: 2 cycles anode=1111, then 6 cycles of 1110/seg=19/dp=0, 1101/30, 1011/24, 0111/79.
  - Sequence repeats every 32 cycles.
- Mid-frame load 16'hABCD during digit 1 -> remainder of frame still shows 1234 digits; next frame shows d(21), C(46), b(03), A(08).
- load 16'h5555 then 16'h6666 in the same frame -> next frame shows 6 (02) on all digits. load asserted exactly on the boundary cycle -> that port value is displayed that frame.
- enable dropped during DRIVE of digit 2 -> next cycle anode=1111. Re-enable -> scan restarts at digit 0 with frame_start, still showing the last active value.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, value=16'h0042 -> digits 3 and 2 seg=7F, digits 1 and 0 show 4 (19) and 2 (24). value=16'h0000 -> digit 0 shows 40, others 7F.
